// File: rtl/codec_sample_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared audio definitions for the codec sample sequencer and its neighbours.
//   SAMPLE_W    : width of one audio sample (matches the FIR data width)
//   sample_t    : signed two's complement audio sample
//   seq_state_t : sequencer FSM states, in transaction order
// ---------------------------------------------------------------------------
package audio_pkg;

  localparam int SAMPLE_W = 24;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    FILTER,
    WAIT_WR,
    WRITE
  } seq_state_t;

endpackage

// File: rtl/codec_sample_sequencer_if.sv
// ---------------------------------------------------------------------------
// codec_sample_sequencer_if
// Codec-side handshake bundle between the audio codec and the sequencer.
//   read_ready  : codec ADC holds a valid stereo pair
//   adc_left/right : ADC sample pair, valid while read_ready=1
//   read        : one-cycle pop strobe to the codec
//   write_ready : codec DAC can accept a pair
//   dac_left/right : pair presented to the codec DAC
//   write       : one-cycle push strobe to the codec
// Modports:
//   master : the sequencer (drives read, write and the DAC pair)
//   slave  : the codec (drives read_ready, write_ready and the ADC pair)
// ---------------------------------------------------------------------------
interface codec_sample_sequencer_if #(
  parameter int SAMPLE_W = audio_pkg::SAMPLE_W
);

  logic                       read_ready;
  logic signed [SAMPLE_W-1:0] adc_left;
  logic signed [SAMPLE_W-1:0] adc_right;
  logic                       read;
  logic                       write_ready;
  logic signed [SAMPLE_W-1:0] dac_left;
  logic signed [SAMPLE_W-1:0] dac_right;
  logic                       write;

  modport master (
    input  read_ready,
    input  adc_left,
    input  adc_right,
    output read,
    input  write_ready,
    output dac_left,
    output dac_right,
    output write
  );

  modport slave (
    output read_ready,
    output adc_left,
    output adc_right,
    input  read,
    output write_ready,
    input  dac_left,
    input  dac_right,
    input  write
  );

endinterface

// File: rtl/codec_sample_sequencer_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with an increment enable.
//   clk   : system clock
//   reset : asynchronous active-low reset, clears the count
//   inc   : add one on this edge unless already at all-ones
//   count : current value, holds at all-ones instead of wrapping
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Once all-ones is reached the counter freezes so a debug read never
  // shows a small value after a long run of stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/codec_sample_sequencer.sv
// ---------------------------------------------------------------------------
// codec_sample_sequencer
// Moves one stereo pair at a time from the codec ADC through a pair of
// external FIR smoothing filters (or around them in bypass) to the codec DAC.
// Ports:
//   clk           : system clock
//   reset         : asynchronous active-low reset
//   codec         : codec handshake bundle (master side)
//   fir_left_in   : registered sample to the left FIR data input
//   fir_right_in  : registered sample to the right FIR data input
//   fir_en        : one-cycle shift enable to both FIRs
//   fir_left_out  : left FIR combinational output
//   fir_right_out : right FIR combinational output
//   bypass        : 1 = DAC receives the raw sample instead of the FIR output
//   stall_count   : saturating count of pairs that waited for write_ready
// ---------------------------------------------------------------------------
module codec_sample_sequencer
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = audio_pkg::SAMPLE_W,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  codec_sample_sequencer_if.master   codec,
  output logic signed [SAMPLE_W-1:0] fir_left_in,
  output logic signed [SAMPLE_W-1:0] fir_right_in,
  output logic                       fir_en,
  input  logic signed [SAMPLE_W-1:0] fir_left_out,
  input  logic signed [SAMPLE_W-1:0] fir_right_out,
  input  logic                       bypass,
  output logic [CNT_W-1:0]           stall_count
);

  seq_state_t state;
  logic       first_wait;
  logic       stall_inc;

  // A pair counts as stalled only once, on its first WAIT_WR cycle, no
  // matter how long the DAC keeps write_ready low afterwards.
  assign stall_inc = (state == WAIT_WR) && first_wait && !codec.write_ready;

  // Single-block Moore FSM. Strobes are registered and asserted on the edge
  // that enters their state, so read/fir_en/write are high for exactly the
  // one cycle spent in CAPTURE/FILTER/WRITE.
  //
  // The DAC registers are loaded on the same edge that shifts the FIRs, so
  // they see the filter output computed from the new sample plus the prior
  // history. The FIRs shift in bypass too, keeping their history continuous.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      first_wait      <= 1'b0;
      codec.read      <= 1'b0;
      fir_en          <= 1'b0;
      codec.write     <= 1'b0;
      fir_left_in     <= '0;
      fir_right_in    <= '0;
      codec.dac_left  <= '0;
      codec.dac_right <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (codec.read_ready) begin
            codec.read <= 1'b1;
            state      <= CAPTURE;
          end
        end

        CAPTURE: begin
          fir_left_in  <= codec.adc_left;
          fir_right_in <= codec.adc_right;
          codec.read   <= 1'b0;
          fir_en       <= 1'b1;
          state        <= FILTER;
        end

        FILTER: begin
          if (bypass) begin
            codec.dac_left  <= fir_left_in;
            codec.dac_right <= fir_right_in;
          end else begin
            codec.dac_left  <= fir_left_out;
            codec.dac_right <= fir_right_out;
          end
          fir_en     <= 1'b0;
          first_wait <= 1'b1;
          state      <= WAIT_WR;
        end

        WAIT_WR: begin
          first_wait <= 1'b0;
          if (codec.write_ready) begin
            codec.write <= 1'b1;
            state       <= WRITE;
          end
        end

        WRITE: begin
          codec.write <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          codec.read  <= 1'b0;
          fir_en      <= 1'b0;
          codec.write <= 1'b0;
          first_wait  <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_counter (
    .clk  (clk),
    .reset(reset),
    .inc  (stall_inc),
    .count(stall_count)
  );

endmodule
